// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment mapping for the seven-segment display path.
package seg_pkg;

  localparam int         NDIG    = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Segment order is gfedcba; a 0 bit lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; kept as a module so other display blocks can share it.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan controller for an 8-digit multiplexed seven-segment display:
// prescaled rotate strobe, double-buffered frame, ghost blanking and
// optional leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic        lz_en,
  output logic        rotate,
  output logic [2:0]  digit_idx,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [31:0]   shadow;
  logic [31:0]   active;
  logic [7:0]    shadow_dp;
  logic [7:0]    active_dp;
  logic          slot_end;
  logic          frame_wrap;
  logic          blank_win;
  logic [3:0]    cur_nib;
  logic [6:0]    dec_seg;
  logic [7:0]    zero_from;
  logic          suppress;

  assign slot_end   = (cnt == CW'(DIV - 1));
  assign frame_wrap = slot_end && (digit_idx == 3'd7);

  // The last cycle of a slot is blanked too, so the dark window covers the
  // cycle rotate is high plus BLANK more once the one-cycle output lag is included.
  assign blank_win  = (cnt < CW'(BLANK)) || slot_end;
  assign cur_nib    = active[{digit_idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // zero_from[k] is set when nibbles 7..k of the active frame are all zero.
  always_comb begin
    zero_from    = '0;
    zero_from[7] = (active[31:28] == 4'h0);
    for (int k = 6; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (active[4*k +: 4] == 4'h0);
    end
    suppress = lz_en && (digit_idx != 3'd0) && zero_from[digit_idx];
  end

  // Prescaler and digit index; rotate marks the first cycle of each new slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      digit_idx <= 3'd0;
      rotate    <= 1'b0;
    end else begin
      rotate <= slot_end;
      if (slot_end) begin
        cnt       <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Shadow/active frame buffers; the active frame only changes at the 7->0 wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow     <= '0;
      shadow_dp  <= '0;
      active     <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_wrap) begin
        if (load) begin
          active     <= data;
          active_dp  <= dp_in;
          shadow     <= data;
          shadow_dp  <= dp_in;
          pending    <= 1'b0;
          frame_done <= 1'b1;
        end else if (pending) begin
          active     <= shadow;
          active_dp  <= shadow_dp;
          pending    <= 1'b0;
          frame_done <= 1'b1;
        end
      end else if (load) begin
        shadow    <= data;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end
    end
  end

  // Registered segment and decimal-point drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (blank_win) begin
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      seg <= suppress ? SEG_OFF : dec_seg;
      dp  <= ~active_dp[digit_idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIV=8, BLANK=2.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic        rotate;
  logic [2:0]  digit_idx;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_done;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .rotate     (rotate),
    .digit_idx  (digit_idx),
    .seg        (seg),
    .dp         (dp),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX_TB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int checks   = 0;
  int failures = 0;

  // Reference model: n = clock edges since reset release.
  int          n = 0;
  logic [31:0] m_act = '0;
  logic [31:0] m_sh  = '0;
  logic [7:0]  m_adp = '0;
  logic [7:0]  m_sdp = '0;
  logic        m_pend = 1'b0;
  logic        e_rot, e_fd, e_dp;
  logic [6:0]  e_seg;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpm;
    logic        lz;
    int          digit;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    int nib;
    nib = int'((m_act >> (4 * d)) & 32'hF);
    if (lz_en && d != 0 && (m_act >> (4 * d)) == 32'd0) return 7'h7F;
    return HEX_TB[nib];
  endfunction

  // Advance one clock, predicting the outputs from the pre-edge state.
  task automatic step();
    int c, d;
    c = n % DIV;
    d = (n / DIV) % 8;
    if (c < BLANK || c == DIV - 1) begin
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_seg = ref_seg(d);
      e_dp  = ~m_adp[d];
    end
    e_rot = (c == DIV - 1);
    e_fd  = 1'b0;
    if (c == DIV - 1 && d == 7) begin
      if (load) begin
        m_act = data; m_adp = dp_in; m_pend = 1'b0; e_fd = 1'b1;
      end else if (m_pend) begin
        m_act = m_sh; m_adp = m_sdp; m_pend = 1'b0; e_fd = 1'b1;
      end
    end else if (load) begin
      m_sh = data; m_sdp = dp_in; m_pend = 1'b1;
    end
    n++;
    @(posedge clk);
    @(negedge clk);
    chk("rotate", rotate, e_rot);
    chk("digit_idx", digit_idx, (n / DIV) % 8);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("pending", pending, m_pend);
    chk("frame_done", frame_done, e_fd);
  endtask

  task automatic run_to(input int phase);
    int k = 0;
    while (n % 64 != phase && k < 200) begin
      step();
      k++;
    end
    if (n % 64 != phase) begin
      checks++;
      failures++;
      $display("FAIL run_to: phase %0d expected %0d", n % 64, phase);
    end
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] p);
    data  = d;
    dp_in = p;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic mid_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_rotate", rotate, 0);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_digit", digit_idx, 0);
    chk("rst_pending", pending, 0);
    chk("rst_frame_done", frame_done, 0);
    n = 0; m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int rot_cnt;

    vt.push_back('{32'h0000_0050, 8'h00, 1'b1, 7, 7'h7F, 1'b1});
    vt.push_back('{32'h0000_0050, 8'h00, 1'b1, 2, 7'h7F, 1'b1});
    vt.push_back('{32'h0000_0050, 8'h00, 1'b1, 1, 7'h12, 1'b1});
    vt.push_back('{32'h0000_0050, 8'h00, 1'b1, 0, 7'h40, 1'b1});
    vt.push_back('{32'h0000_0050, 8'h00, 1'b0, 7, 7'h40, 1'b1});
    vt.push_back('{32'h0000_0050, 8'h00, 1'b0, 2, 7'h40, 1'b1});
    vt.push_back('{32'h0000_0000, 8'h04, 1'b0, 2, 7'h40, 1'b0});
    vt.push_back('{32'h0000_0000, 8'h04, 1'b0, 3, 7'h40, 1'b1});
    vt.push_back('{32'h0000_0000, 8'h04, 1'b1, 2, 7'h7F, 1'b0});
    vt.push_back('{32'hF000_0000, 8'h00, 1'b1, 7, 7'h0E, 1'b1});
    vt.push_back('{32'hF000_0000, 8'h00, 1'b1, 3, 7'h40, 1'b1});

    @(negedge clk);
    @(negedge clk);
    chk("init_seg", seg, 7'h7F);
    chk("init_pending", pending, 0);
    rst = 1'b1;

    // Reset mid-slot with a load still pending.
    repeat (5) step();
    pulse_load(32'hDEAD_BEEF, 8'hFF);
    chk("pending_before_rst", pending, 1);
    repeat (2) step();
    mid_reset();
    rot_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rotate) rot_cnt++;
    end
    chk("first_rotate_at_8", rotate, 1);
    chk("rotates_in_first_8", rot_cnt, 1);

    // Free-run: one rotate per 8 clocks.
    rot_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (rotate) rot_cnt++;
    end
    chk("rotates_in_64", rot_cnt, 8);

    // Deferred load during slot 3.
    run_to(3 * 8 + 1);
    pulse_load(32'h1234_5678, 8'h00);
    chk("deferred_pending", pending, 1);
    run_to(0);
    chk("deferred_frame_done", frame_done, 1);
    chk("deferred_pending_clr", pending, 0);
    run_to(4);
    chk("deferred_slot0_8", seg, 7'b0000000);

    // Load in the commit cycle bypasses the shadow.
    run_to(63);
    pulse_load(32'h0000_000A, 8'h00);
    chk("bypass_frame_done", frame_done, 1);
    chk("bypass_pending", pending, 0);
    run_to(4);
    chk("bypass_slot0_A", seg, 7'b0001000);

    // Table of committed frames and displayed digits.
    foreach (vt[i]) begin
      lz_en = vt[i].lz;
      pulse_load(vt[i].data, vt[i].dpm);
      run_to(0);
      run_to(vt[i].digit * 8 + 4);
      chk($sformatf("vec%0d_digit", i), digit_idx, vt[i].digit);
      chk($sformatf("vec%0d_seg", i), seg, vt[i].seg);
      chk($sformatf("vec%0d_dp", i), dp, vt[i].dp);
    end

    // Random loads, data and lz_en checked against the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        data  = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h0000_0FFF);
        dp_in = 8'($urandom);
        load  = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      step();
      load = 1'b0;
    end

    // A final reset mid-operation.
    pulse_load(32'h8765_4321, 8'h81);
    mid_reset();
    repeat (16) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
